// File: rtl/rr_arb3x64.sv
// Three-requester round-robin arbiter feeding a registered WIDTH-bit output.
// The search starts just after the last granted requester; only a grant moves it.
module rr_arb3x64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic [WIDTH-1:0] dataout,
  output logic             dataout_valid,
  input  logic             dataout_ready,
  output logic [1:0]       s,
  output logic [1:0]       src
);

  logic [1:0]       last;
  logic [1:0]       last_eff;
  logic [1:0]       gnt;
  logic             any;
  logic             load_ok;
  logic             take;
  logic [WIDTH-1:0] mux;

  // An illegal pointer value of 3 behaves exactly like 2.
  assign last_eff = (last == 2'd3) ? 2'd2 : last;

  assign load_ok = !dataout_valid || dataout_ready;

  always_comb begin
    gnt = 2'd0;
    any = 1'b1;
    unique case (last_eff)
      2'd0: begin
        if (b_valid)      gnt = 2'd1;
        else if (c_valid) gnt = 2'd2;
        else if (a_valid) gnt = 2'd0;
        else              any = 1'b0;
      end
      2'd1: begin
        if (c_valid)      gnt = 2'd2;
        else if (a_valid) gnt = 2'd0;
        else if (b_valid) gnt = 2'd1;
        else              any = 1'b0;
      end
      default: begin
        if (a_valid)      gnt = 2'd0;
        else if (b_valid) gnt = 2'd1;
        else if (c_valid) gnt = 2'd2;
        else              any = 1'b0;
      end
    endcase
  end

  assign take = any && load_ok && !reset;

  assign s = take ? gnt : last_eff;

  assign a_ready = take && (gnt == 2'd0);
  assign b_ready = take && (gnt == 2'd1);
  assign c_ready = take && (gnt == 2'd2);

  always_comb begin
    mux = c;
    unique case (1'b1)
      (s == 2'd0): mux = a;
      (s == 2'd1): mux = b;
      default:     mux = c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataout       <= '0;
      dataout_valid <= 1'b0;
      src           <= 2'd0;
      last          <= 2'd2;
    end else if (take) begin
      dataout       <= mux;
      dataout_valid <= 1'b1;
      src           <= gnt;
      last          <= gnt;
    end else if (load_ok) begin
      dataout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb3x64.sv
// Bench for rr_arb3x64: directed vectors plus a cycle-by-cycle
// round-robin reference model and a starvation scoreboard.
module tb_rr_arb3x64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        av = 1'b0;
  logic        bv = 1'b0;
  logic        cv = 1'b0;
  logic        dr = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] c = '0;
  logic        a_ready, b_ready, c_ready;
  logic [63:0] dataout;
  logic        dataout_valid;
  logic [1:0]  s, src;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  bit starv_en = 0;
  int a_wait = 0;

  bit          m_dv = 0;
  logic [63:0] m_dout = '0;
  int          m_src = 0;
  int          m_last = 2;

  rr_arb3x64 #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .a_valid(av), .b_valid(bv), .c_valid(cv),
    .a(a), .b(b), .c(c),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready),
    .dataout(dataout), .dataout_valid(dataout_valid),
    .dataout_ready(dr), .s(s), .src(src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rdy();
    return 64'({c_ready, b_ready, a_ready});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: walk indices last+1, last+2, last+3 (mod 3).
  always @(negedge clk) begin : cmp
    logic [63:0] d [3];
    bit          v [3];
    int          g;
    bit          fnd, lok, gr;
    logic [2:0]  er;
    if (chk_en) begin
      d[0] = a; d[1] = b; d[2] = c;
      v[0] = av; v[1] = bv; v[2] = cv;
      chk("m_dv", 64'(dataout_valid), 64'(m_dv));
      chk("m_dout", dataout, m_dout);
      chk("m_src", 64'(src), 64'(m_src));
      lok = !m_dv || dr;
      fnd = 0;
      g = 0;
      for (int k = 1; k <= 3; k++) begin
        if (!fnd && v[(m_last + k) % 3]) begin
          fnd = 1;
          g = (m_last + k) % 3;
        end
      end
      gr = !reset && lok && fnd;
      er = gr ? 3'(1 << g) : 3'b000;
      chk("m_ready", rdy(), 64'(er));
      chk("m_s", 64'(s), 64'(gr ? g : m_last));
      if (starv_en && gr && av) begin
        if (g == 0) begin
          chk("a_wait_le2", 64'(a_wait <= 2), 64'd1);
          a_wait = 0;
        end else begin
          a_wait++;
        end
      end
      if (reset) begin
        m_dv = 0; m_dout = '0; m_src = 0; m_last = 2;
      end else if (gr) begin
        m_dv = 1; m_dout = d[g]; m_src = g; m_last = g;
      end else if (lok) begin
        m_dv = 0;
      end
    end
  end

  logic [63:0] seq [4];

  initial begin
    seq[0] = 64'h1; seq[1] = 64'h2; seq[2] = 64'h3; seq[3] = 64'h1;
    reset = 1'b1;
    step();
    chk_en = 1;
    av = 1'b1; bv = 1'b1;
    #1;
    chk("rst_ready", rdy(), 64'd0);
    step();
    #1;
    chk("rst_dv", 64'(dataout_valid), 64'd0);
    chk("rst_dout", dataout, 64'd0);
    chk("rst_src", 64'(src), 64'd0);

    av = 1'b0; bv = 1'b0; reset = 1'b0;
    step();
    #1;
    chk("post_rst_s", 64'(s), 64'd2);
    chk("post_rst_dv", 64'(dataout_valid), 64'd0);

    a = 64'h1; b = 64'h2; c = 64'h3;
    av = 1'b1; bv = 1'b1; cv = 1'b1; dr = 1'b1;
    #1;
    chk("rr_first_a", rdy(), 64'b001);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("rr_dout", dataout, seq[i]);
      chk("rr_src", 64'(src), 64'(i % 3));
    end
    av = 1'b0; bv = 1'b0; cv = 1'b0;
    step();
    #1;
    chk("drain_dv", 64'(dataout_valid), 64'd0);

    dr = 1'b0; bv = 1'b1; b = 64'hDEADBEEF_00000001;
    #1;
    chk("bp_b_ready", rdy(), 64'b010);
    step();
    #1;
    chk("bp_dout", dataout, 64'hDEADBEEF_00000001);
    chk("bp_dv", 64'(dataout_valid), 64'd1);
    chk("bp_ready0", rdy(), 64'd0);
    repeat (3) step();
    #1;
    chk("bp_hold", dataout, 64'hDEADBEEF_00000001);
    chk("bp_hold_rdy", rdy(), 64'd0);
    chk("bp_hold_src", 64'(src), 64'd1);

    bv = 1'b0; cv = 1'b1; c = 64'h33; dr = 1'b1;
    #1;
    chk("full_c_ready", rdy(), 64'b100);
    step();
    #1;
    chk("full_dout", dataout, 64'h33);
    chk("full_src", 64'(src), 64'd2);
    chk("full_dv", 64'(dataout_valid), 64'd1);

    cv = 1'b0;
    repeat (10) step();
    #1;
    chk("idle_dv", 64'(dataout_valid), 64'd0);
    chk("idle_s", 64'(s), 64'd2);
    av = 1'b1; bv = 1'b1; cv = 1'b1;
    #1;
    chk("idle_next_a", rdy(), 64'b001);
    step();

    av = 1'b0; bv = 1'b0; dr = 1'b0; reset = 1'b1;
    #1;
    chk("midrst_ready", rdy(), 64'd0);
    step();
    #1;
    chk("midrst_dv", 64'(dataout_valid), 64'd0);
    chk("midrst_dout", dataout, 64'd0);
    reset = 1'b0; av = 1'b1; bv = 1'b1; cv = 1'b1;
    a = 64'h1111; dr = 1'b1;
    #1;
    chk("midrst_a", rdy(), 64'b001);
    step();
    #1;
    chk("midrst_dout_a", dataout, 64'h1111);
    chk("midrst_src_a", 64'(src), 64'd0);

    a_wait = 0;
    starv_en = 1;
    for (int i = 0; i < 60; i++) begin
      av = 1'b1;
      bv = (i % 2) == 1;
      cv = (i % 2) == 0;
      dr = (i % 5) != 4;
      a = 64'hA000 + 64'(i);
      b = 64'hB000 + 64'(i);
      c = 64'hC000 + 64'(i);
      step();
    end
    starv_en = 0;
    av = 1'b0; bv = 1'b0; cv = 1'b0; dr = 1'b1;
    repeat (3) step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
